// File: rtl/temp_control_pkg.sv
// rtl/temp_control_pkg.sv - shared state encoding and default thresholds for temp_control
package temp_control_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEATING = 2'd1,
        COOLING = 2'd2
    } state_e;

    localparam int unsigned DEF_HEAT_ON  = 65;
    localparam int unsigned DEF_HEAT_OFF = 70;
    localparam int unsigned DEF_COOL_OFF = 75;
    localparam int unsigned DEF_COOL_ON  = 80;

    // Hysteresis bands must nest and fit the 8-bit sample range.
    function automatic bit thresholds_ok(input int unsigned heat_on, input int unsigned heat_off,
                                         input int unsigned cool_off, input int unsigned cool_on);
        return (heat_on <= heat_off) && (heat_off <= cool_off) &&
               (cool_off <= cool_on) && (cool_on <= 255);
    endfunction

endpackage

// File: rtl/temp_control_if.sv
// rtl/temp_control_if.sv - temperature sample and threshold flags between FSM and comparator
interface temp_control_if;

    logic [7:0] temp;
    logic       below_heat_on;
    logic       at_or_above_heat_off;
    logic       above_cool_on;
    logic       at_or_below_cool_off;

    modport master (
        output temp,
        input  below_heat_on,
        input  at_or_above_heat_off,
        input  above_cool_on,
        input  at_or_below_cool_off
    );

    modport slave (
        input  temp,
        output below_heat_on,
        output at_or_above_heat_off,
        output above_cool_on,
        output at_or_below_cool_off
    );

endinterface

// File: rtl/temp_control_cmp.sv
// rtl/temp_control_cmp.sv - combinational 8-bit unsigned threshold comparator
module temp_control_cmp
    import temp_control_pkg::*;
#(
    parameter int unsigned HEAT_ON  = DEF_HEAT_ON,
    parameter int unsigned HEAT_OFF = DEF_HEAT_OFF,
    parameter int unsigned COOL_OFF = DEF_COOL_OFF,
    parameter int unsigned COOL_ON  = DEF_COOL_ON
) (
    temp_control_if.slave cmp
);

    localparam logic [7:0] HEAT_ON_C  = 8'(HEAT_ON);
    localparam logic [7:0] HEAT_OFF_C = 8'(HEAT_OFF);
    localparam logic [7:0] COOL_OFF_C = 8'(COOL_OFF);
    localparam logic [7:0] COOL_ON_C  = 8'(COOL_ON);

    // An unknown sample yields unknown flags, which the FSM treats as not-true.
    assign cmp.below_heat_on        = cmp.temp <  HEAT_ON_C;
    assign cmp.at_or_above_heat_off = cmp.temp >= HEAT_OFF_C;
    assign cmp.above_cool_on        = cmp.temp >  COOL_ON_C;
    assign cmp.at_or_below_cool_off = cmp.temp <= COOL_OFF_C;

endmodule

// File: rtl/temp_control.sv
// rtl/temp_control.sv - registered hysteresis thermostat driving exclusive Heat/Cool demands
module temp_control
    import temp_control_pkg::*;
#(
    parameter int unsigned HEAT_ON  = DEF_HEAT_ON,
    parameter int unsigned HEAT_OFF = DEF_HEAT_OFF,
    parameter int unsigned COOL_OFF = DEF_COOL_OFF,
    parameter int unsigned COOL_ON  = DEF_COOL_ON
) (
    output logic       Heat,
    output logic       Cool,
    input  logic       CLK,
    input  logic [7:0] Temp,
    input  logic       Reset
);

    generate
        if (!thresholds_ok(HEAT_ON, HEAT_OFF, COOL_OFF, COOL_ON)) begin : g_bad_thresholds
            $error("temp_control: thresholds must satisfy HEAT_ON <= HEAT_OFF <= COOL_OFF <= COOL_ON <= 255");
        end
    endgenerate

    temp_control_if cmp_bus ();

    assign cmp_bus.temp = Temp;

    temp_control_cmp #(
        .HEAT_ON  (HEAT_ON),
        .HEAT_OFF (HEAT_OFF),
        .COOL_OFF (COOL_OFF),
        .COOL_ON  (COOL_ON)
    ) u_cmp (
        .cmp (cmp_bus)
    );

    state_e state_q, state_d;
    logic   heat_q, heat_d;
    logic   cool_q, cool_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            heat_q  <= heat_d;
            cool_q  <= cool_d;
        end
    end

    // Plain if/else-if: a flag that is not resolved true leaves the state where it is.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmp_bus.below_heat_on)             state_d = HEATING;
                else if (cmp_bus.above_cool_on)        state_d = COOLING;
            end
            HEATING: begin
                if (cmp_bus.above_cool_on)             state_d = COOLING;
                else if (cmp_bus.at_or_above_heat_off) state_d = IDLE;
            end
            COOLING: begin
                if (cmp_bus.below_heat_on)             state_d = HEATING;
                else if (cmp_bus.at_or_below_cool_off) state_d = IDLE;
            end
            default:                                   state_d = IDLE;
        endcase
    end

    // Outputs are registered alongside the state so they track it with no extra cycle.
    always_comb begin
        heat_d = (state_d == HEATING);
        cool_d = (state_d == COOLING);
    end

    assign Heat = heat_q;
    assign Cool = cool_q;

endmodule

// File: tb/tb_temp_control.sv
// tb/tb_temp_control.sv - directed self-checking bench for temp_control
module tb_temp_control;

    logic clk = 1'b0;
    logic rst;
    logic heat;
    logic cool;
    logic monitor_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    temp_control_if tb_bus ();

    temp_control dut (
        .Heat  (heat),
        .Cool  (cool),
        .CLK   (clk),
        .Temp  (tb_bus.temp),
        .Reset (rst)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (monitor_en) begin
            checks++;
            if ((heat & cool) !== 1'b0) begin
                errors++;
                $display("FAIL exclusive heat=%b cool=%b expected heat&cool=0", heat, cool);
            end
        end
    end

    task automatic tick(input logic [7:0] t, input logic r);
        tb_bus.temp = t;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(8'bx, 1'b1);
        checks++;
        if ({heat, cool} !== 2'b00) begin
            errors++;
            $display("FAIL reset_x heat_cool=%b expected=00", {heat, cool});
        end
        monitor_en = 1'b1;
        tick(8'bx, 1'b0);
        if ($isunknown(tb_bus.temp)) begin
            checks++;
            if ({heat, cool} !== 2'b00) begin
                errors++;
                $display("FAIL release_x heat_cool=%b expected=00", {heat, cool});
            end
        end
    endtask

    task automatic test_in_band();
        for (int i = 0; i < 4; i++) begin
            tick(8'd70, 1'b0);
            checks++;
            if ({heat, cool} !== 2'b00) begin
                errors++;
                $display("FAIL in_band[%0d] heat_cool=%b expected=00", i, {heat, cool});
            end
        end
    endtask

    task automatic test_over_temp();
        logic [7:0] t [3] = '{8'd93, 8'd78, 8'd75};
        logic [1:0] e [3] = '{2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) begin
            tick(t[i], 1'b0);
            checks++;
            if ({heat, cool} !== e[i]) begin
                errors++;
                $display("FAIL over_temp temp=%0d heat_cool=%b expected=%b", t[i], {heat, cool}, e[i]);
            end
        end
    endtask

    task automatic test_direct_swing();
        logic [7:0] t [5] = '{8'd93, 8'd60, 8'd69, 8'd70, 8'd70};
        logic [1:0] e [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        for (int i = 0; i < 5; i++) begin
            tick(t[i], 1'b0);
            checks++;
            if ({heat, cool} !== e[i]) begin
                errors++;
                $display("FAIL direct_swing step=%0d temp=%0d heat_cool=%b expected=%b", i, t[i], {heat, cool}, e[i]);
            end
        end
    endtask

    task automatic test_thresholds();
        logic [7:0] t [12] = '{8'd65, 8'd80, 8'd64, 8'd72, 8'd81, 8'd76, 8'd72,
                               8'd0, 8'd72, 8'd255, 8'd75, 8'd72};
        logic [1:0] e [12] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 12; i++) begin
            tick(t[i], 1'b0);
            checks++;
            if ({heat, cool} !== e[i]) begin
                errors++;
                $display("FAIL thresholds step=%0d temp=%0d heat_cool=%b expected=%b", i, t[i], {heat, cool}, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] t [6] = '{8'd50, 8'd50, 8'd50, 8'd200, 8'd200, 8'd200};
        logic       r [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] e [6] = '{2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 6; i++) begin
            tick(t[i], r[i]);
            checks++;
            if ({heat, cool} !== e[i]) begin
                errors++;
                $display("FAIL reset_mid step=%0d temp=%0d reset=%b heat_cool=%b expected=%b",
                         i, t[i], r[i], {heat, cool}, e[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tb_bus.temp = 8'd70;
        @(posedge clk);
        #1;
        test_reset();
        test_in_band();
        test_over_temp();
        test_direct_swing();
        test_thresholds();
        test_reset_mid();
        monitor_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
